forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/forward_scoreboard_pkg.sv | 23 ++
 rtl/forward_scoreboard_prio_sel.sv | 54 +++++
 rtl/forward_scoreboard.sv | 148 ++++++++++++++
 tb/tb_forward_scoreboard.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_scoreboard_pkg.sv
// forward_pkg: shared definitions for the operand-forwarding scoreboard.
//   SEL_RF        : fwd_sel value meaning "read the register file"
//   sel_mc()      : fwd_sel value meaning "take the multicycle result" (FWD_STAGES+1)
//   sel_w()       : width of one fwd_sel field, clog2(FWD_STAGES+2)
//   mc_state_t    : multicycle tracker state
package forward_pkg;

    localparam int SEL_RF = 0;

    function automatic int sel_w(input int fwd_stages);
        return $clog2(fwd_stages + 2);
    endfunction

    function automatic int sel_mc(input int fwd_stages);
        return fwd_stages + 1;
    endfunction

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/forward_scoreboard_prio_sel.sv
// fwd_prio_sel: match and priority logic for one decode source operand.
//   src_reg/src_valid          : source index and "is read" flag
//   stg_rd/stg_we/stg_ready    : per-stage destination, write enable, result ready
//   mc_busy/mc_done/mc_rd      : multicycle tracker state and pending destination
//   sel                        : 0 = regfile, k = stage k-1, FWD_STAGES+1 = mc result
//   stall                      : this source cannot be satisfied this cycle
module fwd_prio_sel
    import forward_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int REG_W      = 5,
    parameter int SEL_W      = 2
) (
    input  logic [REG_W-1:0]            src_reg,
    input  logic                        src_valid,
    input  logic [FWD_STAGES*REG_W-1:0] stg_rd,
    input  logic [FWD_STAGES-1:0]       stg_we,
    input  logic [FWD_STAGES-1:0]       stg_ready,
    input  logic                        mc_busy,
    input  logic                        mc_done,
    input  logic [REG_W-1:0]            mc_rd,
    output logic [SEL_W-1:0]            sel,
    output logic                        stall
);

    logic w_nz;
    logic w_hit;
    logic w_hit_ready;
    logic w_mc_match;

    assign w_nz       = (src_reg != '0);
    assign w_mc_match = mc_busy && w_nz && (src_reg == mc_rd);

    always_comb begin
        sel         = SEL_W'(SEL_RF);
        w_hit       = 1'b0;
        w_hit_ready = 1'b1;
        // Walk oldest to youngest so the youngest match is the one left standing.
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (src_valid && w_nz && stg_we[k] && (stg_rd[k*REG_W +: REG_W] == src_reg)) begin
                sel         = SEL_W'(k + 1);
                w_hit       = 1'b1;
                w_hit_ready = stg_ready[k];
            end
        end
        // The multicycle result only counts on its writeback cycle and only
        // when no younger pipeline producer shadows it.
        if (!w_hit && mc_done && w_mc_match) begin
            sel = SEL_W'(sel_mc(FWD_STAGES));
        end
        stall = (w_hit && !w_hit_ready) || (src_valid && w_mc_match && !mc_done);
    end

endmodule

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: decode-stage forwarding select and hazard stall for a
// multi-source pipeline with one outstanding multicycle (mult/div) op.
//   clock, reset            : rising-edge clock, async active-high reset
//   src_reg, src_valid      : packed decode sources, port i at [i*REG_W +: REG_W]
//   dec_rd, dec_we          : decode destination (WAW against the multicycle op)
//   stg_rd, stg_we, stg_ready : per forwarding stage, stage 0 youngest
//   mc_issue, mc_rd, mc_done  : multicycle op start / writeback
//   stall_clr               : zero the stall counter
//   fwd_sel, stall          : combinational select fields and decode hold
//   mc_busy, mc_err, stall_cnt : registered tracker state, sticky error, counter
module forward_scoreboard
    import forward_pkg::*;
#(
    parameter  int SRC_PORTS  = 4,
    parameter  int FWD_STAGES = 2,
    parameter  int REG_W      = 5,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = sel_w(FWD_STAGES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SRC_PORTS*REG_W-1:0]  src_reg,
    input  logic [SRC_PORTS-1:0]        src_valid,
    input  logic [REG_W-1:0]            dec_rd,
    input  logic                        dec_we,
    input  logic [FWD_STAGES*REG_W-1:0] stg_rd,
    input  logic [FWD_STAGES-1:0]       stg_we,
    input  logic [FWD_STAGES-1:0]       stg_ready,
    input  logic                        mc_issue,
    input  logic [REG_W-1:0]            mc_rd,
    input  logic                        mc_done,
    input  logic                        stall_clr,
    output logic [SRC_PORTS*SEL_W-1:0]  fwd_sel,
    output logic                        stall,
    output logic                        mc_busy,
    output logic                        mc_err,
    output logic [CNT_W-1:0]            stall_cnt
);

    mc_state_t        r_state;
    mc_state_t        w_state_nxt;
    logic [REG_W-1:0] r_pend_rd;
    logic [REG_W-1:0] w_pend_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_issue_ok;
    logic             w_busy;
    logic             w_waw;
    logic [SRC_PORTS-1:0] w_src_stall;

    assign w_busy = (r_state == MC_BUSY);

    // ---------------------------------------------------------------
    // Per-source select / stall
    // ---------------------------------------------------------------
    for (genvar g = 0; g < SRC_PORTS; g++) begin : g_src
        fwd_prio_sel #(
            .FWD_STAGES (FWD_STAGES),
            .REG_W      (REG_W),
            .SEL_W      (SEL_W)
        ) u_sel (
            .src_reg   (src_reg[g*REG_W +: REG_W]),
            .src_valid (src_valid[g]),
            .stg_rd    (stg_rd),
            .stg_we    (stg_we),
            .stg_ready (stg_ready),
            .mc_busy   (w_busy),
            .mc_done   (mc_done),
            .mc_rd     (r_pend_rd),
            .sel       (fwd_sel[g*SEL_W +: SEL_W]),
            .stall     (w_src_stall[g])
        );
    end

    // A younger write to the pending destination would be overwritten by the
    // late multicycle result, so decode holds until that result lands.
    assign w_waw = dec_we && (dec_rd != '0) && w_busy && !mc_done && (dec_rd == r_pend_rd);
    assign stall = (|w_src_stall) || w_waw;

    // ---------------------------------------------------------------
    // Multicycle tracker
    // ---------------------------------------------------------------
    // An issue to r0 has no architectural effect and is dropped silently.
    assign w_issue_ok = mc_issue && (mc_rd != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_rd;
        w_err_nxt   = r_err;
        case (r_state)
            MC_IDLE: begin
                if (mc_done) w_err_nxt = 1'b1;
                if (w_issue_ok) begin
                    w_state_nxt = MC_BUSY;
                    w_pend_nxt  = mc_rd;
                end
            end
            MC_BUSY: begin
                if (mc_done) begin
                    // Back-to-back: retire the old op and accept the new one.
                    if (w_issue_ok) begin
                        w_pend_nxt = mc_rd;
                    end else begin
                        w_state_nxt = MC_IDLE;
                        w_pend_nxt  = '0;
                    end
                end else if (w_issue_ok) begin
                    w_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = MC_IDLE;
                w_pend_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= MC_IDLE;
            r_pend_rd <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_rd <= w_pend_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Stall counter (saturating)
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (stall_clr) begin
            r_cnt <= '0;
        end else if (stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign mc_busy   = w_busy;
    assign mc_err    = r_err;
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;

    localparam int SP = 4;
    localparam int FS = 2;
    localparam int RW = 5;
    localparam int CW = 8;
    localparam int SW = 2;
    localparam int MC_SEL = FS + 1;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic                clock = 1'b0;
    logic                reset;
    logic [SP*RW-1:0]    src_reg;
    logic [SP-1:0]       src_valid;
    logic [RW-1:0]       dec_rd;
    logic                dec_we;
    logic [FS*RW-1:0]    stg_rd;
    logic [FS-1:0]       stg_we;
    logic [FS-1:0]       stg_ready;
    logic                mc_issue;
    logic [RW-1:0]       mc_rd;
    logic                mc_done;
    logic                stall_clr;
    logic [SP*SW-1:0]    fwd_sel;
    logic                stall;
    logic                mc_busy;
    logic                mc_err;
    logic [CW-1:0]       stall_cnt;

    forward_scoreboard #(.SRC_PORTS(SP), .FWD_STAGES(FS), .REG_W(RW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .src_reg(src_reg), .src_valid(src_valid),
        .dec_rd(dec_rd), .dec_we(dec_we), .stg_rd(stg_rd), .stg_we(stg_we),
        .stg_ready(stg_ready), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_done(mc_done),
        .stall_clr(stall_clr), .fwd_sel(fwd_sel), .stall(stall), .mc_busy(mc_busy),
        .mc_err(mc_err), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // Reference model state: one pending multicycle destination or none.
    bit      m_busy;
    int      m_rd;
    bit      m_err;
    int      m_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int src_of(input int i);
        return int'(src_reg[i*RW +: RW]);
    endfunction

    function automatic int stg_of(input int k);
        return int'(stg_rd[k*RW +: RW]);
    endfunction

    // Producer for source i: youngest writing stage, else the mc result on
    // its writeback cycle, else the register file.
    function automatic int exp_sel(input int i);
        int r = src_of(i);
        if (src_valid[i] && r != 0)
            for (int k = 0; k < FS; k++)
                if (stg_we[k] && stg_of(k) == r) return k + 1;
        if (m_busy && mc_done && r != 0 && r == m_rd) return MC_SEL;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit s = 0;
        for (int i = 0; i < SP; i++) begin
            int e = exp_sel(i);
            if (e >= 1 && e <= FS && !stg_ready[e-1]) s = 1;
            if (src_valid[i] && src_of(i) != 0 && m_busy && !mc_done && src_of(i) == m_rd) s = 1;
        end
        if (dec_we && dec_rd != 0 && m_busy && !mc_done && int'(dec_rd) == m_rd) s = 1;
        return s;
    endfunction

    task automatic idle_inputs();
        src_reg = '0; src_valid = '0; dec_rd = '0; dec_we = 1'b0;
        stg_rd = '0; stg_we = '0; stg_ready = '1;
        mc_issue = 1'b0; mc_rd = '0; mc_done = 1'b0; stall_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_rd = 0; m_err = 0; m_cnt = 0;
    endtask

    // Inputs are already applied; check the combinational outputs, advance
    // the model over one edge, then check the registered outputs.
    task automatic cycle(input string tag);
        bit s;
        bit iss;
        #2;
        for (int i = 0; i < SP; i++)
            check({tag, ".sel"}, 64'(fwd_sel[i*SW +: SW]), 64'(exp_sel(i)));
        s = exp_stall();
        check({tag, ".stall"}, 64'(stall), 64'(s));
        if (stall_clr) m_cnt = 0;
        else if (s && m_cnt < CNT_MAX) m_cnt++;
        iss = mc_issue && mc_rd != 0;
        if (!m_busy) begin
            if (mc_done) m_err = 1;
            if (iss) begin m_busy = 1; m_rd = int'(mc_rd); end
        end else if (mc_done) begin
            if (iss) m_rd = int'(mc_rd);
            else begin m_busy = 0; m_rd = 0; end
        end else if (iss) begin
            m_err = 1;
        end
        @(posedge clock); #1;
        check({tag, ".busy"}, 64'(mc_busy), 64'(m_busy));
        check({tag, ".err"}, 64'(mc_err), 64'(m_err));
        check({tag, ".cnt"}, 64'(stall_cnt), 64'(m_cnt));
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #12;
        check("rst.busy", 64'(mc_busy), 64'd0);
        check("rst.err", 64'(mc_err), 64'd0);
        check("rst.cnt", 64'(stall_cnt), 64'd0);
        check("rst.sel", 64'(fwd_sel), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Both stages write r5: youngest stage wins.
        src_reg[0 +: RW] = 5'd5; src_valid = 4'b0001;
        stg_rd = {5'd5, 5'd5}; stg_we = 2'b11; stg_ready = 2'b11;
        #2;
        check("youngest.sel0", 64'(fwd_sel[SW-1:0]), 64'd1);
        check("youngest.stall", 64'(stall), 64'd0);
        #(-0); cycle("youngest");

        // Load-use on source 1.
        idle_inputs();
        src_reg[RW +: RW] = 5'd7; src_valid = 4'b0010;
        stg_rd[0 +: RW] = 5'd7; stg_we = 2'b01; stg_ready = 2'b10;
        cycle("loaduse");
        check("loaduse.cnt1", 64'(stall_cnt), 64'd1);

        // Multicycle op to r9, dependent source waits, then forwards.
        idle_inputs();
        mc_issue = 1'b1; mc_rd = 5'd9;
        cycle("mc.issue");
        idle_inputs();
        src_reg[0 +: RW] = 5'd9; src_valid = 4'b0001;
        for (int c = 0; c < 3; c++) cycle("mc.wait");
        mc_done = 1'b1;
        #2;
        check("mc.done.sel", 64'(fwd_sel[SW-1:0]), 64'(MC_SEL));
        check("mc.done.stall", 64'(stall), 64'd0);
        cycle("mc.done");
        check("mc.idle", 64'(mc_busy), 64'd0);

        // Issue while busy is an error; pending destination is kept.
        idle_inputs();
        mc_issue = 1'b1; mc_rd = 5'd9;
        cycle("err.issue1");
        mc_rd = 5'd12;
        cycle("err.issue2");
        check("err.sticky", 64'(mc_err), 64'd1);
        idle_inputs();
        src_reg[0 +: RW] = 5'd9; src_valid = 4'b0001;
        cycle("err.pend9");
        // WAW against pending r9.
        idle_inputs();
        dec_rd = 5'd9; dec_we = 1'b1;
        cycle("waw");
        // Back-to-back retire + issue r4.
        idle_inputs();
        mc_done = 1'b1; mc_issue = 1'b1; mc_rd = 5'd4;
        cycle("b2b");
        check("b2b.busy", 64'(mc_busy), 64'd1);
        idle_inputs();
        src_reg[2*RW +: RW] = 5'd4; src_valid = 4'b0100;
        cycle("b2b.pend4");
        // Issue to r0 while busy: ignored, no new error source.
        idle_inputs();
        mc_issue = 1'b1; mc_rd = 5'd0;
        cycle("r0.issue");

        // r0 never forwards.
        idle_inputs();
        src_valid = 4'b1111; stg_we = 2'b11; stg_ready = 2'b00;
        cycle("r0.src");

        // Reset in the middle of an op with stall_cnt at 12.
        idle_inputs();
        stall_clr = 1'b1;
        cycle("clr");
        idle_inputs();
        src_reg[0 +: RW] = 5'd4; src_valid = 4'b0001;
        for (int c = 0; c < 12; c++) cycle("pre.rst");
        check("pre.rst.cnt", 64'(stall_cnt), 64'd12);
        #2; reset = 1'b1; #1;
        model_reset();
        check("midrst.busy", 64'(mc_busy), 64'd0);
        check("midrst.cnt", 64'(stall_cnt), 64'd0);
        check("midrst.err", 64'(mc_err), 64'd0);
        check("midrst.stall", 64'(stall), 64'd0);
        idle_inputs();
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;

        // Saturation: 2^CW+3 stalled cycles.
        src_reg[RW +: RW] = 5'd7; src_valid = 4'b0010;
        stg_rd[0 +: RW] = 5'd7; stg_we = 2'b01; stg_ready = 2'b10;
        for (int c = 0; c < (1 << CW) + 3; c++) cycle("sat");
        check("sat.cnt", 64'(stall_cnt), 64'(CNT_MAX));
        stall_clr = 1'b1;
        cycle("sat.clr");
        check("sat.clr0", 64'(stall_cnt), 64'd0);

        // Randomized traffic over a small register window to force hits.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < SP; i++) src_reg[i*RW +: RW] = 5'($urandom_range(0, 7));
            for (int k = 0; k < FS; k++) stg_rd[k*RW +: RW] = 5'($urandom_range(0, 7));
            src_valid = 4'($urandom);
            stg_we    = 2'($urandom);
            stg_ready = 2'($urandom_range(0, 3) | (($urandom_range(0, 3) == 0) ? 0 : 3));
            dec_rd    = 5'($urandom_range(0, 7));
            dec_we    = 1'($urandom);
            mc_issue  = ($urandom_range(0, 5) == 0);
            mc_rd     = 5'($urandom_range(0, 7));
            mc_done   = ($urandom_range(0, 4) == 0);
            stall_clr = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
